// File: rtl/sample_delay_pkg.sv
// Shared constants and helpers for the sample delay line.
// Holds the default word width and depth, and the width of the fill counter.
package sample_delay_pkg;

    localparam int WIDTH_DEFAULT = 20;
    localparam int DEPTH_DEFAULT = 4;

    // The fill counter saturates at depth, so it needs to hold 0..depth inclusive
    function automatic int fill_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One WIDTH-bit storage stage of the delay line.
// Loads d when enabled, clears to zero on clr, and resets synchronously on rst.
module delay_stage #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next value: clear beats load, otherwise hold
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = d;
        end
    end

    // Stage register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sample_delay_line.sv
// Sample-rate delay line with a selectable output tap and a fill counter.
// Optional feature macro: SAMPLE_DELAY_LINE_TAPS_EN exposes every stage on taps;
// without it taps is tied to zero.
module sample_delay_line
    import sample_delay_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_en,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(DEPTH)-1:0] delay_sel,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic [DEPTH*WIDTH-1:0]   taps
);

    localparam int SEL_W  = $clog2(DEPTH);
    localparam int FILL_W = fill_width(DEPTH);

    logic             advance;
    logic [WIDTH-1:0] stage [DEPTH];
    logic [FILL_W-1:0] fill_d;
    logic [FILL_W-1:0] fill_q;
    logic [SEL_W-1:0]  eff_sel;

    assign advance = sample_en & ~flush & ~rst;

    // The chain of stages: stage 0 takes the new sample, the rest shift along
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] stage_in;
        if (k == 0) begin : g_first
            assign stage_in = in_data;
        end else begin : g_next
            assign stage_in = stage[k-1];
        end
        delay_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk(clk),
            .rst(rst),
            .clr(flush),
            .en (advance),
            .d  (stage_in),
            .q  (stage[k])
        );
    end

    // Fill count: cleared by flush, counts advances, saturates at DEPTH
    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = '0;
        end else if (advance && (fill_q < FILL_W'(DEPTH))) begin
            fill_d = fill_q + 1'b1;
        end
    end

    // Fill count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    // Clamp out-of-range selects (non-power-of-two DEPTH) onto the last stage
    always_comb begin
        eff_sel = delay_sel;
        if (32'(delay_sel) >= 32'(DEPTH)) begin
            eff_sel = SEL_W'(DEPTH - 1);
        end
    end

    // Output tap is purely combinational so a select change shows immediately
    always_comb begin
        out_data  = stage[eff_sel];
        out_valid = 32'(fill_q) > 32'(eff_sel);
    end

`ifdef SAMPLE_DELAY_LINE_TAPS_EN
    // Flatten all stages onto taps, stage k in its own WIDTH-bit slot
    always_comb begin
        taps = '0;
        for (int k = 0; k < DEPTH; k++) begin
            taps[k*WIDTH +: WIDTH] = stage[k];
        end
    end
`else
    assign taps = '0;
`endif

endmodule

// File: tb/tb_sample_delay_line.sv
// Self-checking bench for sample_delay_line (WIDTH=20, DEPTH=4).
// Reference: a queue of the samples captured since the last reset/flush.
module tb_sample_delay_line;

    localparam int WIDTH = 20;
    localparam int DEPTH = 4;
    localparam int SEL_W = $clog2(DEPTH);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   sample_en;
    logic                   flush;
    logic [WIDTH-1:0]       in_data;
    logic [SEL_W-1:0]       delay_sel;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic [DEPTH*WIDTH-1:0] taps;

    int vec_count = 0;
    int err_count = 0;

    logic [WIDTH-1:0] hist [$];

    sample_delay_line #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sample_en(sample_en),
        .flush    (flush),
        .in_data  (in_data),
        .delay_sel(delay_sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .taps     (taps)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vec_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // k-th most recent captured sample, or 0 if the line has not filled that far
    function automatic logic [WIDTH-1:0] modelStage(input int k);
        if (k < hist.size()) return hist[hist.size()-1-k];
        return '0;
    endfunction

    task automatic checkAll(input string tag);
        int sel;
        logic [DEPTH*WIDTH-1:0] exp_taps;
        sel = (int'(delay_sel) >= DEPTH) ? DEPTH - 1 : int'(delay_sel);
        exp_taps = '0;
`ifdef SAMPLE_DELAY_LINE_TAPS_EN
        for (int k = 0; k < DEPTH; k++) exp_taps[k*WIDTH +: WIDTH] = modelStage(k);
`endif
        checkOutput({tag, ".data"},  128'(out_data),  128'(modelStage(sel)));
        checkOutput({tag, ".valid"}, 128'(out_valid), 128'(hist.size() > sel));
        checkOutput({tag, ".taps"},  128'(taps),      128'(exp_taps));
    endtask

    // Drive one cycle of inputs, clock it, update the reference, settle
    task automatic applyStimulus(input logic r, input logic en, input logic fl,
                                 input logic [WIDTH-1:0] din, input logic [SEL_W-1:0] sel);
        rst       = r;
        sample_en = en;
        flush     = fl;
        in_data   = din;
        delay_sel = sel;
        @(posedge clk);
        if (r || fl) begin
            hist.delete();
        end else if (en) begin
            hist.push_back(din);
            if (hist.size() > DEPTH) void'(hist.pop_front());
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; sample_en = 1'b0; flush = 1'b0; in_data = '0; delay_sel = '0;
        #2;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 20'hABCDE, '0);
        checkAll("reset");
        checkOutput("reset.data0", 128'(out_data), 128'(0));

        // Back-to-back capture at delay 0: one cycle of latency
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'(i), '0);
            checkAll($sformatf("seq0_%0d", i));
            checkOutput($sformatf("seq0_const%0d", i), 128'(out_data), 128'(i));
            checkOutput($sformatf("seq0_valid%0d", i), 128'(out_valid), 128'(1));
        end

        // Strobe every third cycle at delay 3
        applyStimulus(1'b0, 1'b0, 1'b1, '0, 2'd3);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'(20'hA + i), 2'd3);
            checkAll($sformatf("strobe_adv%0d", i));
            if (i == 2) checkOutput("strobe_notvalid", 128'(out_valid), 128'(0));
            if (i == 3) checkOutput("strobe_firstA", 128'(out_data), 128'(20'hA));
            if (i == 4) checkOutput("strobe_secondB", 128'(out_data), 128'(20'hB));
            for (int j = 0; j < 2; j++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, WIDTH'($urandom), 2'd3);
                checkAll($sformatf("strobe_hold%0d_%0d", i, j));
            end
        end

        // Flush wins over a simultaneous sample
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'(i * 'h11), 2'd3);
        checkAll("flush_full");
        applyStimulus(1'b0, 1'b1, 1'b1, 20'h55, 2'd0);
        checkAll("flush");
        checkOutput("flush_taps0", 128'(taps), 128'(0));
        checkOutput("flush_valid0", 128'(out_valid), 128'(0));

        // Mid-stream reset, then refill at delay 2
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'($urandom), 2'd2);
        applyStimulus(1'b1, 1'b1, 1'b0, 20'h77777, 2'd2);
        checkAll("midrst");
        checkOutput("midrst_data0", 128'(out_data), 128'(0));
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'($urandom), 2'd2);
            checkAll($sformatf("refill%0d", i));
            checkOutput($sformatf("refill_valid%0d", i), 128'(out_valid), 128'(i == 3));
        end

        // Full line, sweep the select with no clock edge in between
        applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'($urandom), 2'd0);
        for (int s = 0; s < DEPTH; s++) begin
            delay_sel = SEL_W'(s);
            #1;
            checkAll($sformatf("sweep%0d", s));
            checkOutput($sformatf("sweep_valid%0d", s), 128'(out_valid), 128'(1));
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 29) == 0), WIDTH'($urandom),
                          SEL_W'($urandom_range(0, DEPTH - 1)));
            checkAll($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/sample_delay_line.md
SAMPLE_DELAY_LINE -- requirements
Module: sample_delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 20, sample word width in bits (legal 1..32).
REQ-002 SHALL have parameter DEPTH, default 4, number of delay stages (legal 2..64).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port sample_en  input  1  sample-rate strobe; the line advances only in cycles where it is high.
REQ-006 SHALL have port flush  input  1  synchronous clear of all stages and the fill count.
REQ-007 SHALL have port in_data  input  WIDTH  sample captured into stage 0 on an advance.
REQ-008 SHALL have port delay_sel  input  clog2(DEPTH)  selects output delay of delay_sel+1 advances.
REQ-009 SHALL have port out_data  output  WIDTH  content of stage[delay_sel].
REQ-010 SHALL have port out_valid  output  1  high when the selected stage holds a sample captured since the last reset or flush.
REQ-011 SHALL have port taps  output  DEPTH*WIDTH  flat concatenation of all stages, stage k at bits [k*WIDTH +: WIDTH].

Function
REQ-012 Advance = sample_en high and flush low and rst low; on an advance stage[0] SHALL load in_data and stage[k] SHALL load stage[k-1] for k=1..DEPTH-1, all in the same edge.
REQ-013 Without an advance, every stage SHALL hold its value.
REQ-014 out_data SHALL be a combinational select of stage[delay_sel]; no added register latency.
REQ-015 With sample_en tied high and delay_sel=0, out_data SHALL equal in_data delayed by exactly one clk cycle.
REQ-016 A sample captured on advance n SHALL appear on out_data after advance n+delay_sel.
REQ-017 delay_sel >= DEPTH (non-power-of-two DEPTH) SHALL select stage[DEPTH-1].
REQ-018 A fill counter SHALL increment by 1 on each advance, saturating at DEPTH; no wrap-around.
REQ-019 out_valid SHALL be high iff fill count > min(delay_sel, DEPTH-1); a delay_sel change SHALL take effect combinationally.
REQ-020 flush high SHALL clear every stage to 0 and fill count to 0 on that edge; flush with sample_en in the same cycle SHALL discard the sample (flush wins).
REQ-021 Arithmetic: none on data; samples pass bit-exact, sign not interpreted.

Reset
REQ-022 rst SHALL clear all stages to 0 and fill count to 0 on the next rising clk edge, overriding flush and sample_en.
REQ-023 After reset, out_data=0, out_valid=0, taps=0.
REQ-024 rst asserted mid-stream SHALL discard all stored samples; first advance after deassertion refills from stage 0.

Configuration
REQ-025 Macro SAMPLE_DELAY_LINE_TAPS_EN defined: taps SHALL drive all stage contents per REQ-011.
REQ-026 Macro SAMPLE_DELAY_LINE_TAPS_EN undefined: taps port SHALL remain present but be tied to 0; out_data/out_valid behaviour unchanged.

Structure
REQ-027 Package sample_delay_pkg SHALL hold WIDTH_DEFAULT=20, DEPTH_DEFAULT=4, and the fill-count width function/constant.
REQ-028 One sub-module delay_stage SHALL implement a single WIDTH-bit register with enable and synchronous clear; sample_delay_line SHALL instantiate DEPTH of them via generate.

Verification
REQ-029 WIDTH=20, DEPTH=4, sample_en=1, delay_sel=0, in_data=0x00001,0x00002,0x00003 on consecutive cycles -> out_data 0x00001,0x00002,0x00003 one cycle later each; out_valid high from the first edge after the first capture.
REQ-030 delay_sel=3, sample_en every 3rd cycle, inputs 0xA,0xB,0xC,0xD,0xE -> out_valid rises after the 4th advance with out_data=0xA; after the 5th advance out_data=0xB; out_data stable between strobes.
REQ-031 Line full of 0x11,0x22,0x33,0x44; assert flush with sample_en=1, in_data=0x55 -> all taps 0, out_valid=0, 0x55 not captured.
REQ-032 Mid-stream rst=1 for one cycle with sample_en=1 -> all outputs 0 next cycle; refill needs delay_sel+1 advances before out_valid=1.
REQ-033 Full line, delay_sel swept 0..3 with no advance -> out_data steps through stage[0..3] same cycle, out_valid stays 1; rerun without SAMPLE_DELAY_LINE_TAPS_EN -> taps=0 throughout, out_data identical.
